// File: rtl/vga_roi_capture.sv
// Grabs the on-screen input box from the displayed VGA frame, averages each
// SCALE x SCALE block and streams the OUT_DIM x OUT_DIM result into the CNN buffer.
module vga_roi_capture #(
  parameter int ROI_ROW0  = 184,
  parameter int ROI_COL0  = 320,
  parameter int SCALE     = 4,
  parameter int OUT_DIM   = 28,
  parameter int LINE_LAST = 751
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic       vga_vsync,
  input  logic       vga_hsync,
  input  logic       active_video,
  input  logic [7:0] rgb_data_i,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       capture_err,
  output logic       wr_en,
  output logic [9:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [1:0] dbg_state_o
);

  localparam int SH    = $clog2(SCALE);
  localparam int BOX   = SCALE * OUT_DIM;
  localparam int IW    = $clog2(OUT_DIM);
  localparam int ACC_W = 8 + 2 * SH;

  localparam logic [9:0]    ROW_LO   = 10'(ROI_ROW0);
  localparam logic [9:0]    ROW_HI   = 10'(ROI_ROW0 + BOX);
  localparam logic [9:0]    COL_LO   = 10'(ROI_COL0);
  localparam logic [9:0]    COL_HI   = 10'(ROI_COL0 + BOX);
  localparam logic [9:0]    LAST_COL = 10'(LINE_LAST);
  localparam logic [IW-1:0] LAST_IDX = IW'(OUT_DIM - 1);
  localparam logic [SH-1:0] SUB_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [9:0]        col_q, col_d;
  logic [9:0]        row_q, row_d;
  logic              wrote_q, wrote_d;
  logic              wr_en_q, wr_en_d;
  logic [9:0]        wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ACC_W-1:0]  acc_q [OUT_DIM];

  logic [9:0]        rr, cc;
  logic [IW-1:0]     by, bx;
  logic [SH-1:0]     sr, sc;
  logic              in_roi, take, blk_load, blk_end, last_blk;
  logic [ACC_W-1:0]  acc_base, acc_sum;

  // Raster counters: every comparison below uses the pre-update values.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (vga_hsync)         col_d = '0;
    else if (active_video) col_d = col_q + 10'd1;
    if (vga_vsync)                              row_d = '0;
    else if (active_video && col_q == LAST_COL) row_d = row_q + 10'd1;
  end

  always_comb begin
    rr       = row_q - ROW_LO;
    cc       = col_q - COL_LO;
    by       = rr[SH +: IW];
    bx       = cc[SH +: IW];
    sr       = rr[SH-1:0];
    sc       = cc[SH-1:0];
    in_roi   = active_video && (row_q >= ROW_LO) && (row_q < ROW_HI) &&
               (col_q >= COL_LO) && (col_q < COL_HI);
    take     = (state_q == S_CAPTURE) && in_roi;
    blk_load = (sr == '0) && (sc == '0);
    blk_end  = (sr == SUB_LAST) && (sc == SUB_LAST);
    last_blk = take && blk_end && (by == LAST_IDX) && (bx == LAST_IDX);
    acc_base = blk_load ? '0 : acc_q[bx];
    acc_sum  = acc_base + ACC_W'(rgb_data_i);
  end

  // capture_err only when this frame already produced a write, so a vsync
  // that is still high when CAPTURE is entered stays silent.
  always_comb begin
    state_d   = state_q;
    wrote_d   = wrote_q;
    err_d     = 1'b0;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ARMED;
      end
      S_ARMED: begin
        wrote_d = 1'b0;
        if (vga_vsync) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        err_d = vga_vsync && wrote_q;
        if (take && blk_end) begin
          wr_en_d   = 1'b1;
          wr_addr_d = 10'(by) * 10'(OUT_DIM) + 10'(bx);
          wr_data_d = acc_sum[2*SH +: 8];
          wrote_d   = 1'b1;
        end else if (vga_vsync) begin
          wrote_d = 1'b0;
        end
        if (last_blk) begin
          done_d  = 1'b1;
          wrote_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      wrote_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < OUT_DIM; i++) acc_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      wrote_q   <= wrote_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      if (take) acc_q[bx] <= acc_sum;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign capture_err = err_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign dbg_state_o = state_q;

endmodule
